// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Segments are active-high, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Hex-to-segment table, entry 15 first so that SEG_TABLE[n] encodes n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Value-in / segments-out bundle of the display scan controller.
interface display_scan_controller_if;
    logic [7:0] number;
    logic       hex_mode;
    logic [6:0] seg7;
    logic [3:0] select;
    logic       busy;

    // The value source (e.g. computer) side.
    modport master (output number, hex_mode, input seg7, select, busy);
    // The display controller side.
    modport slave  (input number, hex_mode, output seg7, select, busy);
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial 8-bit binary to 3-digit BCD converter (double-dabble, one bit per cycle).
module bin2bcd_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] bcd_o
);
    // {hundreds, tens, ones, binary remainder}
    logic [19:0] sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        busy_q, busy_d;
    logic [11:0] adj;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Next state: load on start, otherwise add-3 then shift once per busy cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        adj       = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8])};
        if (busy_q) begin
            sr_d      = {adj, sr_q[7:0]} << 1;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            sr_d      = {12'd0, value_i};
            bit_cnt_d = 3'd7;
            busy_d    = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy_o = busy_q;
    // Last shift cycle; the result is stable in sr_q from the following cycle.
    assign done_o = busy_q && (bit_cnt_q == 3'd0);
    assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/display_scan_controller.sv
// 4-digit 7-segment scan controller: change detect, BCD/hex conversion, blanking, multiplexing.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int CLK_HZ   = 20_000_000,
    parameter int DIGIT_HZ = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    display_scan_controller_if.slave  bus
);
    localparam int               SCAN_DIV  = CLK_HZ / DIGIT_HZ;
    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam int               IDX_W     = $clog2(NUM_DIGITS);

    conv_state_e      state_q, state_d;
    logic [7:0]       last_number_q, last_number_d;
    logic             pending_q, pending_d;
    logic             hex_conv_q, hex_conv_d;
    logic             hex_latched_q, hex_latched_d;
    logic [2:0][3:0]  digit_q, digit_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic [6:0]       seg7_q, seg7_d;
    logic [3:0]       select_q, select_d;
    logic             start;
    logic             bcd_busy;
    logic             bcd_done;
    logic [11:0]      bcd;
    logic             scan_wrap;
    logic [3:0]       shown_nib;
    logic             shown_blank;

    bin2bcd_serial u_bin2bcd (
        .clk     (clk),
        .rst     (reset),
        .start_i (start),
        .value_i (bus.number),
        .busy_o  (bcd_busy),
        .done_o  (bcd_done),
        .bcd_o   (bcd)
    );

    // Change detect and conversion sequencing; COMMIT publishes the finished digits.
    always_comb begin
        state_d       = state_q;
        last_number_d = last_number_q;
        pending_d     = pending_q;
        hex_conv_d    = hex_conv_q;
        hex_latched_d = hex_latched_q;
        digit_d       = digit_q;
        start         = 1'b0;
        if (bus.number != last_number_q) begin
            pending_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    start         = 1'b1;
                    last_number_d = bus.number;
                    hex_conv_d    = bus.hex_mode;
                    pending_d     = 1'b0;
                    state_d       = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bcd_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                hex_latched_d = hex_conv_q;
                if (hex_conv_q) begin
                    digit_d = {4'd0, last_number_q[7:4], last_number_q[3:0]};
                end else begin
                    digit_d = bcd;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan timing, blanking and segment lookup; uses the next digit values so a commit shows one cycle later.
    always_comb begin
        scan_wrap   = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = scan_wrap ? digit_idx_q + 1'b1 : digit_idx_q;
        select_d    = scan_wrap ? 4'b0000 : (4'b0001 << digit_idx_q);
        shown_nib   = 4'd0;
        shown_blank = 1'b1;
        case (digit_idx_q)
            2'd0: begin
                shown_nib   = digit_d[0];
                shown_blank = 1'b0;
            end
            2'd1: begin
                shown_nib   = digit_d[1];
                shown_blank = !hex_latched_d && (digit_d[2] == 4'd0) && (digit_d[1] == 4'd0);
            end
            2'd2: begin
                shown_nib   = digit_d[2];
                shown_blank = hex_latched_d || (digit_d[2] == 4'd0);
            end
            default: begin
                shown_nib   = 4'd0;
                shown_blank = 1'b1;
            end
        endcase
        seg7_d = (scan_wrap || shown_blank) ? SEG_BLANK : seg_encode(shown_nib);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_number_q <= '0;
            pending_q     <= 1'b0;
            hex_conv_q    <= 1'b0;
            hex_latched_q <= 1'b0;
            // NOTE: the digit registers are reset on purpose so the display shows "0" straight after reset.
            digit_q       <= '0;
            scan_cnt_q    <= '0;
            digit_idx_q   <= '0;
            seg7_q        <= SEG_BLANK;
            select_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_number_q <= last_number_d;
            pending_q     <= pending_d;
            hex_conv_q    <= hex_conv_d;
            hex_latched_q <= hex_latched_d;
            digit_q       <= digit_d;
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            seg7_q        <= seg7_d;
            select_q      <= select_d;
        end
    end

    assign bus.seg7   = seg7_q;
    assign bus.select = select_q;
    assign bus.busy   = bcd_busy || (state_q == ST_COMMIT);

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Sequencer for the board's 4-digit 7-segment display, driven by the 8-bit output value of `computer`. It watches the value for changes and converts it to decimal BCD serially (double-dabble, one bit per cycle). It then time-multiplexes the 4 digit selects at a fixed refresh rate, with leading-zero blanking, an optional hex mode and one dead cycle between digits. It runs on the 20 MHz PLL clock alongside `computer`.

## Interface
- `CLK_HZ`, 20_000_000: input clock frequency.
- `DIGIT_HZ`, 1000: per-digit dwell rate. `SCAN_DIV = CLK_HZ / DIGIT_HZ`; must be ≥ 2.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `number`  in  8  value to display, sampled every cycle.
- `hex_mode`  in  1  0 = decimal 0–255, 1 = hex 00–FF. Sampled at conversion start.
- `seg7`  out  7  segments, active-high, bit0 = a … bit6 = g. Registered.
- `select`  out  4  one-hot digit enable, active-high, bit0 = rightmost digit. Registered.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Change detect:
  - `last_number` register, reset to 0.
  - When `number != last_number`, set `pending`. Starting a conversion captures `number` into `last_number` and clears `pending`.
- Conversion FSM, states IDLE → SHIFT → COMMIT → IDLE:
  - IDLE: if `pending` is set, load the shift register with `last_number` and `bit_cnt = 7`, then go to SHIFT.
  - SHIFT: 8 cycles. Each cycle, add 3 to any BCD nibble ≥ 5, then shift left one bit. Leave SHIFT after the `bit_cnt == 0` cycle.
  - COMMIT: write the `digit[2:0]` registers and `hex_latched`, then return to IDLE.
- Hex mode: SHIFT is still traversed, so latency is identical. COMMIT writes `digit[1:0]` from the raw nibbles and `digit[2]` = 0.
- `number` changing during SHIFT/COMMIT does not abort the current conversion. `pending` is set, and a new conversion starts from IDLE on the cycle after COMMIT. Only the latest value is ever converted.
- Blanking:
  - Decimal mode: digit 3 is always blank. Digit 2 is blank if it is 0. Digit 1 is blank if digits 2 and 1 are both 0. Digit 0 is never blank.
  - Hex mode: digits 3 and 2 are blank.
  - A blank digit drives `seg7 = 0` while its select is asserted.
- Scan:
  - `scan_cnt` counts 0 … `SCAN_DIV-1`. On wrap, `digit_idx` advances 0→1→2→3→0.
  - On the wrap cycle, `select = 0` (dead cycle, prevents ghosting). All other cycles, `select = 1 << digit_idx`.
  - The scan never stalls for conversions. It displays the committed registers only, so a digit never shows partial data.
- Segment encoding covers 0–F; blank is 7'b0.

## Timing
- Reset values:
  - Outputs: `seg7 = 0`, `select = 0`, `busy = 0`.
  - Internal: `scan_cnt = 0`, `digit_idx = 0`, digits = 0, state = IDLE, `pending = 0`, `last_number = 0`.
- First non-dead scan cycle after reset release shows digit 0 = "0" (7'b0111111).
- Latency, decimal and hex:
  - `number` changes at cycle N; `pending` is set at N+1.
  - SHIFT runs N+2 … N+9; COMMIT is at N+10.
  - New digit values appear on `seg7` from N+11, whenever that digit is selected.
- `busy` is high from the first SHIFT cycle through COMMIT: 9 cycles per conversion.
- Back-to-back conversions: 10 cycles apart (IDLE, 8×SHIFT, COMMIT).
- Asserting `reset` mid-conversion forces IDLE, discards partial results and clears digits to 0. It also clears `last_number`, so a held nonzero `number` reconverts after release.
- Each digit is selected for `SCAN_DIV-1` cycles, followed by 1 dead cycle. Full frame = 4 × `SCAN_DIV` cycles.

## Structure
- Shared package `display_pkg`:
  - FSM state enum (IDLE/SHIFT/COMMIT).
  - `SEG_BLANK` and the 16-entry hex-to-segment constant table.
  - `NUM_DIGITS = 4`.
- Sub-module `bin2bcd_serial`: shift register, `bit_cnt`, add-3 logic and start/busy/done handshake. It owns SHIFT.
- The parent owns change detect, COMMIT, blanking and scan.

## Test plan
- Bench parameters: `CLK_HZ = 16`, `DIGIT_HZ = 4`, giving `SCAN_DIV = 4`.
- Reset release with `number = 0`:
  - `select` sequence 0,1,1,1,0,2,2,2,0,4,4,4,0,8,8,8.
  - `seg7 = 7'b0111111` while digit 0 is selected; `seg7 = 0` on digits 1–3.
  - `busy` never rises.
- `number = 8'd255`, decimal mode:
  - `busy` high for exactly 9 cycles.
  - Digits 2/1/0 = 2/5/5 from N+11; digit 3 blank.
- `number = 8'd7` → only digit 0 lit (7). `number = 8'd40` → digit 1 = 4, digit 0 = 0, digit 2 blank.
- `hex_mode = 1`, `number = 8'hA3` → digit 1 = A (7'b1110111), digit 0 = 3, digits 3/2 blank; same latency as decimal.
- Value change mid-conversion: 12 → 200 at the 3rd SHIFT cycle.
  - First conversion commits 12.
  - Second starts the cycle after COMMIT and commits 200.
  - `busy` shows 9 high, 1 low, 9 high.
- Reset asserted during SHIFT of 255:
  - Outputs return to reset values immediately; digits read 0.
  - After release with 255 still applied, 255 reconverts and displays.
